// File: rtl/pss_tx_pkg.sv
// Shared types and helpers for the PSS transmit chain.
// Holds the sample packing, the read-FSM state type, the saturation limits
// and the bin-to-sequence index mapping used by the subcarrier mapper.
package pss_tx_pkg;

  localparam int SAMPLE_DW = 16;

  // One complex sample: imaginary part in the upper half, real part in the lower half
  typedef struct packed {
    logic signed [SAMPLE_DW-1:0] imag;
    logic signed [SAMPLE_DW-1:0] re;
  } sample_t;

  localparam logic signed [SAMPLE_DW-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_DW-1:0] SAT_MIN = 16'sh8000;

  // Read side of the mapper: waiting for a full bank, or streaming one frame out
  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // Result of a bin lookup: hit=1 means the bin carries seq[k], otherwise it is zero-filled
  typedef struct packed {
    logic        hit;
    logic [15:0] k;
  } seq_idx_t;

  // Maps an IFFT bin (natural order) onto an index of the DC-centred sequence
  function automatic seq_idx_t bin_to_seq_idx(input int b, input int nfft,
                                              input int seq_len, input bit dc_null);
    int       s;
    int       k;
    seq_idx_t r;
    s     = (b < nfft / 2) ? b : b - nfft;
    k     = s + (seq_len - 1) / 2;
    r.hit = (k >= 0) && (k < seq_len) && !(dc_null && (b == 0));
    r.k   = k[15:0];
    return r;
  endfunction

endpackage

// File: rtl/mapper_pingpong_buf.sv
// Ping-pong sample store for the subcarrier mapper.
// Two register banks of SEQ_LEN samples each, a full flag per bank and
// separate write/read bank pointers. Reads are combinational so the top
// can fold the lookup straight into its output register.
module mapper_pingpong_buf
  import pss_tx_pkg::*;
#(
  parameter int SW      = 32,
  parameter int SEQ_LEN = 63,
  parameter int AW      = $clog2(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [SW-1:0] wr_data_i,
  input  logic          wr_last_i,
  input  logic          rd_free_i,
  input  logic          rd_next_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [SW-1:0] rd_data_o,
  output logic          wr_full_o,
  output logic          rd_full_o,
  output logic          rd_other_full_o
);

  logic [SW-1:0] mem_q [2][SEQ_LEN];
  logic [1:0]    full_q, full_d;
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic          rd_bank;

  // Sample storage; contents are only meaningful while the bank's full flag is set
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wptr_q][wr_addr_i] <= wr_data_i;
    end
  end

  // The last write marks its bank full, the last read frees its bank; they never hit the same bank
  always_comb begin
    full_d = full_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en_i && wr_last_i) begin
      full_d[wptr_q] = 1'b1;
      wptr_d         = ~wptr_q;
    end
    if (rd_free_i) begin
      full_d[rptr_q] = 1'b0;
      rptr_d         = ~rptr_q;
    end
  end

  // Bank bookkeeping; reset empties both banks and points both sides at bank 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 2'b00;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign rd_bank         = rptr_q ^ rd_next_i;
  assign rd_data_o       = mem_q[rd_bank][rd_addr_i];
  assign wr_full_o       = full_q[wptr_q];
  assign rd_full_o       = full_q[rptr_q];
  assign rd_other_full_o = full_q[~rptr_q];

endmodule

// File: rtl/pss_subcarrier_mapper.sv
// PSS subcarrier mapper: loads a SEQ_LEN-sample ZC sequence into a ping-pong
// buffer and streams one NFFT-bin IFFT input frame in natural bin order with
// the sequence centred on DC; unused bins are zero, bin 0 optionally nulled.
// Optional feature macro: PSS_MAPPER_BOOST_EN adds the gain_shift port, a
// saturating left shift of each component applied in the output register.
module pss_subcarrier_mapper
  import pss_tx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SEQ_LEN = 63,
  parameter int NFFT    = 128,
  parameter int DC_NULL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
`ifdef PSS_MAPPER_BOOST_EN
  ,
  input  logic [1:0]          gain_shift
`endif
);

  localparam int SW = 2 * DATA_W;
  localparam int AW = $clog2(SEQ_LEN);
  localparam int BW = $clog2(NFFT);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ready_en_q;
  logic [SW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          wr_beat;
  logic          wr_last;
  logic          wr_full;
  logic          rd_full;
  logic          rd_other_full;
  logic          rd_free;
  logic          rd_next;
  logic [BW-1:0] load_bin;
  seq_idx_t      map;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_data;
  logic [SW-1:0] bin_sample;
  logic [SW-1:0] boosted;

  assign wr_beat  = in_valid && in_ready;
  assign wr_last  = (wcnt_q == AW'(SEQ_LEN - 1));
  assign in_ready = ready_en_q && !wr_full;

  mapper_pingpong_buf #(
    .SW      (SW),
    .SEQ_LEN (SEQ_LEN),
    .AW      (AW)
  ) u_buf (
    .clk             (clk),
    .rst             (rst),
    .wr_en_i         (wr_beat),
    .wr_addr_i       (wcnt_q),
    .wr_data_i       (in_data),
    .wr_last_i       (wr_last),
    .rd_free_i       (rd_free),
    .rd_next_i       (rd_next),
    .rd_addr_i       (rd_addr),
    .rd_data_o       (rd_data),
    .wr_full_o       (wr_full),
    .rd_full_o       (rd_full),
    .rd_other_full_o (rd_other_full)
  );

  // Write counter walks 0..SEQ_LEN-1 and wraps when the bank is completed
  always_comb begin
    wcnt_d = wcnt_q;
    if (wr_beat) begin
      wcnt_d = wr_last ? '0 : wcnt_q + AW'(1);
    end
  end

  // Bin to load next: bin 0 when starting a frame (from idle or straight after the last bin), else bcnt
  always_comb begin
    rd_next  = (state_q == RD_STREAM) && out_last_q;
    load_bin = ((state_q == RD_IDLE) || out_last_q) ? '0 : bcnt_q;
  end

  // Zero-fill / DC-null mux in front of the output register
  always_comb begin
    map        = bin_to_seq_idx(int'(load_bin), NFFT, SEQ_LEN, DC_NULL != 0);
    rd_addr    = map.hit ? map.k[AW-1:0] : '0;
    bin_sample = map.hit ? rd_data : '0;
  end

`ifdef PSS_MAPPER_BOOST_EN
  localparam int EW = DATA_W + 3;

  function automatic logic [DATA_W-1:0] sat_shift(input logic [DATA_W-1:0] x,
                                                  input logic [1:0] sh);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] hi;
    logic signed [EW-1:0] lo;
    ext = EW'($signed(x)) <<< sh;
    hi  = $signed({{(EW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    lo  = ~hi;
    if (ext > hi) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (ext < lo) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end
    return ext[DATA_W-1:0];
  endfunction

  // Saturating boost of both components; zero bins stay zero since 0 << n = 0
  always_comb begin
    boosted = {sat_shift(bin_sample[SW-1:DATA_W], gain_shift),
               sat_shift(bin_sample[DATA_W-1:0], gain_shift)};
  end
`else
  // Without the boost option samples pass through bit-exact
  always_comb begin
    boosted = bin_sample;
  end
`endif

  // Read FSM: start a frame when the read bank fills, advance on each accepted beat, chain frames without a bubble
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_free     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_full) begin
          state_d     = RD_STREAM;
          out_data_d  = boosted;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          bcnt_d      = BW'(1);
        end
      end
      RD_STREAM: begin
        if (out_ready) begin
          if (out_last_q) begin
            rd_free = 1'b1;
            if (rd_other_full) begin
              out_data_d  = boosted;
              out_valid_d = 1'b1;
              out_last_d  = 1'b0;
              bcnt_d      = BW'(1);
            end else begin
              state_d     = RD_IDLE;
              out_data_d  = '0;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              bcnt_d      = '0;
            end
          end else begin
            out_data_d = boosted;
            out_last_d = (bcnt_q == BW'(NFFT - 1));
            bcnt_d     = bcnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // State, counters and output register; reset drops everything including any partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      ready_en_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      ready_en_q  <= 1'b1;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
